// File: rtl/debounce_pulse.sv
// Button/switch debouncer with a 2-flop synchronizer and one-cycle edge strobes.
// level_out only moves after the synchronized input has disagreed with it for
// STABLE_COUNT consecutive clocks; any agreeing cycle restarts the qualification.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// STABLE_LOW   | level_out = 0, synchronized input agrees
// WAIT_HIGH    | level_out = 0, input high, counting qualifying cycles
// STABLE_HIGH  | level_out = 1, synchronized input agrees
// WAIT_LOW     | level_out = 1, input low, counting qualifying cycles
module debounce_pulse #(
    parameter int STABLE_COUNT = 50000,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    // The counter must be able to hold STABLE_COUNT-1, and 1 must be a valid
    // load value that is still below the terminal count.
    if (STABLE_COUNT < 2 || STABLE_COUNT > (2 ** CNT_W) - 1) begin : g_bad_param
        $error("debounce_pulse: STABLE_COUNT out of range for CNT_W");
    end

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // Two-stage synchronizer for the asynchronous button level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    // State, stability counter and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic: qualify the new level, reject bounces, and raise the
    // strobe on the same edge that commits the new level so both appear together.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (sync2_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!sync2_q) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sync2_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (sync2_q) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_out  = (state_q == STABLE_HIGH) || (state_q == WAIT_LOW);
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Self-checking bench for debounce_pulse: directed scenarios followed by random
// button activity, all compared against a history-based reference model.
module tb_debounce_pulse;

    localparam int SC = 4;
    localparam int CW = 3;

    logic clk;
    logic reset;
    logic btn_in;
    logic level_out;
    logic rise_pulse;
    logic fall_pulse;

    int n_checks;
    int n_fails;

    // Reference model: input delayed by two edges, plus the list of delayed
    // samples seen since the last level change.
    bit m_s1;
    bit m_s2;
    bit m_lvl;
    bit m_rise;
    bit m_fall;
    bit hist[$];

    debounce_pulse #(.STABLE_COUNT(SC), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0;
        m_s2 = 0;
        m_lvl = 0;
        m_rise = 0;
        m_fall = 0;
        hist.delete();
    endtask

    // One rising edge: the level flips when the last SC delayed samples all
    // disagree with the current level.
    task automatic model_edge();
        bit all_diff;
        hist.push_back(m_s2);
        while (hist.size() > SC) void'(hist.pop_front());
        m_rise = 0;
        m_fall = 0;
        if (hist.size() == SC) begin
            all_diff = 1;
            foreach (hist[i]) if (hist[i] == m_lvl) all_diff = 0;
            if (all_diff) begin
                m_lvl = ~m_lvl;
                if (m_lvl) m_rise = 1;
                else m_fall = 1;
                hist.delete();
            end
        end
        m_s2 = m_s1;
        m_s1 = btn_in;
    endtask

    // Called at a falling edge; drives inputs, runs one clock, returns at the
    // next falling edge after comparing against the model.
    task automatic step(input logic b, input logic r);
        btn_in = b;
        reset  = r;
        if (!r) begin
            model_reset();
            #1;
            check("rst_level", int'(level_out), 0);
            check("rst_rise", int'(rise_pulse), 0);
            check("rst_fall", int'(fall_pulse), 0);
        end
        @(posedge clk);
        if (r) model_edge();
        @(negedge clk);
        check("level", int'(level_out), int'(m_lvl));
        check("rise", int'(rise_pulse), int'(m_rise));
        check("fall", int'(fall_pulse), int'(m_fall));
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b1);
    endtask

    // Drive a clean level and count clock edges until level_out follows it;
    // the first edge counted is the one that first samples the new level.
    task automatic measure(input string tag, input logic b, input int exp_edges);
        int n;
        bit seen_pulse;
        n = 0;
        seen_pulse = 0;
        while (level_out != b && n < 20) begin
            step(b, 1'b1);
            n++;
        end
        seen_pulse = b ? rise_pulse : fall_pulse;
        check(tag, n, exp_edges);
        check({tag, "_pulse"}, int'(seen_pulse), 1);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        btn_in   = 1'b1;
        reset    = 1'b0;
        model_reset();
        #1;
        check("por_level", int'(level_out), 0);
        check("por_rise", int'(rise_pulse), 0);
        @(negedge clk);

        // Reset held 40 ns with the button already pressed.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        measure("rst_release_lat", 1'b1, SC + 2);
        hold(1'b1, 6);

        // Clean release then clean press.
        measure("release_lat", 1'b0, SC + 2);
        hold(1'b0, 6);
        measure("press_lat", 1'b1, SC + 2);
        hold(1'b1, 6);
        hold(1'b0, 10);

        // Bounce, then settle high.
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        measure("bounce_lat", 1'b1, SC + 2);
        hold(1'b1, 6);
        hold(1'b0, 10);

        // Glitch shorter than the qualification window.
        hold(1'b1, SC - 1);
        hold(1'b0, 8);
        check("glitch_level", int'(level_out), 0);
        check("glitch_cnt", int'(dut.cnt_q), 0);

        // Reset in the middle of WAIT_HIGH, then a full latency after release.
        hold(1'b1, 4);
        step(1'b1, 1'b0);
        measure("midwait_lat", 1'b1, SC + 2);
        hold(1'b1, 4);

        // Random activity with occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            logic b;
            int   len;
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * SC + 2);
            if ($urandom_range(0, 40) == 0) step(b, 1'b0);
            hold(b, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 SHALL have parameter STABLE_COUNT, default 50000: number of consecutive clk cycles the synchronized input must differ from level_out before level_out toggles.
REQ-002 SHALL have parameter CNT_W, default 16: stability counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port btn_in, input, 1: raw, bouncing, asynchronous button/switch level.
REQ-006 SHALL have port level_out, output, 1: debounced level; drives d of the downstream enabled flip-flop.
REQ-007 SHALL have port rise_pulse, output, 1: one-cycle strobe on a debounced 0->1 transition; drives en of the downstream flip-flop.
REQ-008 SHALL have port fall_pulse, output, 1: one-cycle strobe on a debounced 1->0 transition.

Function
REQ-009 SHALL pass btn_in through a 2-flop synchronizer (sync1 -> sync2); only sync2 feeds the logic.
REQ-010 SHALL implement FSM states STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW; level_out = 1 in STABLE_HIGH and WAIT_LOW, else 0.
REQ-011 STABLE_LOW -> WAIT_HIGH when sync2 = 1; STABLE_HIGH -> WAIT_LOW when sync2 = 0; counter loads 1 on that transition.
REQ-012 In WAIT_x, counter increments each cycle sync2 differs from level_out; any cycle sync2 equals level_out returns FSM to the matching STABLE state and clears counter (bounce rejection).
REQ-013 When in WAIT_HIGH with counter = STABLE_COUNT-1 and sync2 = 1: next state STABLE_HIGH, counter cleared, rise_pulse = 1 for exactly that one cycle in which level_out first reads 1.
REQ-014 Symmetric for WAIT_LOW: next state STABLE_LOW, fall_pulse = 1 for the single cycle in which level_out first reads 0.
REQ-015 Latency: clean btn_in step sampled at edge k -> level_out changes at edge k+1+STABLE_COUNT (2 sync stages plus STABLE_COUNT qualifying cycles).
REQ-016 Counter SHALL never exceed STABLE_COUNT-1 and SHALL never wrap.
REQ-017 rise_pulse and fall_pulse SHALL be registered, mutually exclusive, never high in consecutive cycles.
REQ-018 A glitch shorter than STABLE_COUNT cycles (at sync2) SHALL produce no level_out change and no pulse.
REQ-019 STABLE_COUNT SHALL be >= 2 and <= 2^CNT_W - 1; violation is an elaboration error.

Reset
REQ-020 reset = 0 SHALL immediately (no clk needed) force sync1 = 0, sync2 = 0, counter = 0, FSM = STABLE_LOW, level_out = 0, rise_pulse = 0, fall_pulse = 0.
REQ-021 Reset asserted mid-WAIT or during a pulse SHALL abort it; no pulse emitted during reset.
REQ-022 If btn_in is high at reset release, level_out SHALL rise after the REQ-015 latency and rise_pulse SHALL fire once.
REQ-023 Reset deassertion is assumed synchronous to clk at the system level; block needs no internal reset synchronizer.

Verification (STABLE_COUNT = 4, CNT_W = 3, clk period 20 ns)
REQ-024 Reset: reset = 0 for 40 ns with btn_in = 1 -> all outputs 0 during reset; after release level_out = 1 at 6th edge, rise_pulse high that one cycle.
REQ-025 Clean press: btn_in 0->1, held 200 ns -> level_out 0->1 exactly 5 edges after first sampling edge; rise_pulse single cycle; fall_pulse stays 0.
REQ-026 Bounce: btn_in toggles 1,0,1,0 every 20 ns then holds 1 -> no pulse during bounce; single rise_pulse 5 edges after final stable 1 is sampled.
REQ-027 Release: from level_out = 1, btn_in -> 0 held -> level_out 1->0, one fall_pulse, rise_pulse 0.
REQ-028 Short glitch: btn_in high for 3 cycles only -> level_out stays 0, no pulses, counter back to 0.
REQ-029 Reset mid-wait: btn_in high, reset = 0 after 2 WAIT_HIGH cycles -> outputs 0 at once; no rise_pulse until full latency elapses after release.
